// File: rtl/adder_arbiter_pkg.sv
// Shared definitions for adder_arbiter: FSM encoding, op codes, widths.
package adder_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   localparam int ID_W   = 1;
   localparam int DATA_W = 32;

endpackage

// File: rtl/adder_arbiter_adder.sv
// adder: 32-bit two's-complement adder with carry-in.
// The sum is formed 33 bits wide on sign-extended operands. result carries
// the low 31 bits; cout carries the top two bits {s32, s31}, so the full
// 32-bit sum is {cout[0], result} and signed overflow is cout[1] ^ cout[0].
module adder
   import adder_arbiter_pkg::*;
(
   input  logic [DATA_W-1:0] operand1,
   input  logic [DATA_W-1:0] operand2,
   input  logic              cin,
   output logic [DATA_W-2:0] result,
   output logic [1:0]        cout
);

   logic [DATA_W:0] sum;

   assign sum    = {operand1[DATA_W-1], operand1}
                 + {operand2[DATA_W-1], operand2}
                 + {{DATA_W{1'b0}}, cin};
   assign result = sum[DATA_W-2:0];
   assign cout   = sum[DATA_W:DATA_W-1];

endmodule

// File: rtl/adder_arbiter.sv
// adder_arbiter: shares one adder between two valid/ready requesters.
// IDLE grants and captures operands, CALC drives the adder and registers
// the result, DONE holds it until out_valid && out_ready.
// Config macro ADDER_ARB_RR_EN: defined -> round-robin tie-break,
// undefined -> fixed priority (requester 0 wins ties, no pointer register).
module adder_arbiter
   import adder_arbiter_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [DATA_W-1:0] req0_a,
   input  logic [DATA_W-1:0] req0_b,
   input  logic              req0_sub,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [DATA_W-1:0] req1_a,
   input  logic [DATA_W-1:0] req1_b,
   input  logic              req1_sub,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ID_W-1:0]   out_id,
   output logic [DATA_W-1:0] out_result,
   output logic              out_overflow,
   output logic              busy
);

   state_t            state, state_nxt;
   logic [1:0]        grant;
   logic              prio;
   logic [DATA_W-1:0] op_a, op_b;
   logic              op_sub;
   logic [ID_W-1:0]   op_id;
   logic [DATA_W-1:0] operand2;
   logic              cin;
   logic [DATA_W-2:0] sum_lo;
   logic [1:0]        cout;

`ifdef ADDER_ARB_RR_EN
   // Tie-break pointer: after any grant, priority moves to the other side
   always_ff @(posedge clk) begin
      if (reset)
         prio <= 1'b0;
      else if (state == ST_IDLE && grant != 2'b00)
         prio <= grant[0];
   end
`else
   assign prio = 1'b0;
`endif

   // Grant: a lone valid always wins, ties go to the priority holder
   always_comb begin
      grant = {req1_valid, req0_valid};
      if (req0_valid && req1_valid)
         grant = prio ? 2'b10 : 2'b01;
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (grant != 2'b00)          state_nxt = ST_CALC;
         ST_CALC:                              state_nxt = ST_DONE;
         ST_DONE: if (out_ready)               state_nxt = ST_IDLE;
         default:                              state_nxt = ST_IDLE;
      endcase
   end

   // FSM outputs: readys only while idle, result valid only in DONE
   always_comb begin
      req0_ready = (state == ST_IDLE) && grant[0];
      req1_ready = (state == ST_IDLE) && grant[1];
      out_valid  = (state == ST_DONE);
      busy       = (state != ST_IDLE);
   end

   // Operand capture on grant, so requesters may move on immediately
   always_ff @(posedge clk) begin
      if (reset) begin
         op_a   <= '0;
         op_b   <= '0;
         op_sub <= OP_ADD;
         op_id  <= '0;
      end else if (state == ST_IDLE && grant != 2'b00) begin
         if (grant[1]) begin
            op_a   <= req1_a;
            op_b   <= req1_b;
            op_sub <= req1_sub;
            op_id  <= ID_W'(1);
         end else begin
            op_a   <= req0_a;
            op_b   <= req0_b;
            op_sub <= req0_sub;
            op_id  <= ID_W'(0);
         end
      end
   end

   // Subtract is a + ~b + 1
   assign operand2 = (op_sub == OP_SUB) ? ~op_b : op_b;
   assign cin      = (op_sub == OP_SUB);

   adder u_adder (
      .operand1 (op_a),
      .operand2 (operand2),
      .cin      (cin),
      .result   (sum_lo),
      .cout     (cout)
   );

   // Result registers: loaded only at the end of CALC, held through DONE
   always_ff @(posedge clk) begin
      if (reset) begin
         out_result   <= '0;
         out_overflow <= 1'b0;
         out_id       <= '0;
      end else if (state == ST_CALC) begin
         out_result   <= {cout[0], sum_lo};
         out_overflow <= cout[1] ^ cout[0];
         out_id       <= op_id;
      end
   end

endmodule

// File: tb/tb_adder_arbiter.sv
// Bench for adder_arbiter: directed vectors with literal expectations plus a
// cycle-by-cycle comparison against a behavioural model of the arbiter.
module tb_adder_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req0_valid = 1'b0, req1_valid = 1'b0;
   logic        req0_ready, req1_ready;
   logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic        req0_sub = 1'b0, req1_sub = 1'b0;
   logic        out_valid, out_ready = 1'b1;
   logic        out_id;
   logic [31:0] out_result;
   logic        out_overflow, busy;

   int n_tests = 0;
   int n_fail  = 0;
   logic chk_en = 1'b0;

   always #5 clk = ~clk;

   adder_arbiter dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
      .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id),
      .out_result(out_result), .out_overflow(out_overflow), .busy(busy)
   );

   task automatic chk1(input string nm, input logic act, input logic exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b, expected %b", nm, act, exp);
      end
   endtask

   task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Arithmetic in wide signed integers; overflow = true result out of int32 range.
   function automatic logic [32:0] calc(input logic [31:0] a, input logic [31:0] b, input logic sub);
      longint sa, sb, full;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      full = sub ? (sa - sb) : (sa + sb);
      calc = {(full > 64'sd2147483647) || (full < -64'sd2147483648), full[31:0]};
   endfunction

   function automatic int winner(input logic v0, input logic v1, input logic p);
      if (v0 && v1) return p ? 1 : 0;
      return v0 ? 0 : 1;
   endfunction

   logic        m_calc, m_have, m_prio, m_id, m_ovf;
   logic [31:0] m_res;

   // Model: one accepted op occupies one compute cycle, then waits for the consumer
   always @(posedge clk) begin
      if (reset) begin
         m_calc <= 1'b0;
         m_have <= 1'b0;
         m_prio <= 1'b0;
      end else if (m_have) begin
         if (out_ready) m_have <= 1'b0;
      end else if (m_calc) begin
         m_calc <= 1'b0;
         m_have <= 1'b1;
      end else if (req0_valid || req1_valid) begin
         m_calc <= 1'b1;
         if (winner(req0_valid, req1_valid, m_prio) == 1) begin
            m_id <= 1'b1;
            {m_ovf, m_res} <= calc(req1_a, req1_b, req1_sub);
         end else begin
            m_id <= 1'b0;
            {m_ovf, m_res} <= calc(req0_a, req0_b, req0_sub);
         end
`ifdef ADDER_ARB_RR_EN
         m_prio <= (winner(req0_valid, req1_valid, m_prio) == 0);
`endif
      end
   end

   logic m_free;
   int   m_w;

   // Compare process: every cycle, away from the active edge
   always @(negedge clk) begin
      if (chk_en) begin
         m_free = !m_calc && !m_have;
         m_w    = winner(req0_valid, req1_valid, m_prio);
         chk1("model req0_ready", req0_ready, m_free && req0_valid && (m_w == 0));
         chk1("model req1_ready", req1_ready, m_free && req1_valid && (m_w == 1));
         chk1("model busy", busy, !m_free);
         chk1("model out_valid", out_valid, m_have);
         if (m_have) begin
            chk1("model out_id", out_id, m_id);
            chk32("model out_result", out_result, m_res);
            chk1("model out_overflow", out_overflow, m_ovf);
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic issue(input int who, input logic [31:0] a, input logic [31:0] b, input logic sub);
      @(posedge clk); #1;
      if (who == 0) begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_sub = sub; end
      else          begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_sub = sub; end
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if ((who == 0) ? req0_ready : req1_ready) begin
            @(posedge clk); #1;
            if (who == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
            return;
         end
      end
      chk1("issue grant timeout", 1'b0, 1'b1);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
   endtask

   task automatic expect_out(input string nm, input logic id, input logic [31:0] res, input logic ovf);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (out_valid) begin
            chk1({nm, " out_id"}, out_id, id);
            chk32({nm, " out_result"}, out_result, res);
            chk1({nm, " out_overflow"}, out_overflow, ovf);
            return;
         end
      end
      chk1({nm, " out_valid timeout"}, 1'b0, 1'b1);
   endtask

   initial begin
      // reset state, and a request during reset must not be granted
      @(posedge clk); #1 chk_en = 1'b1;
      @(negedge clk);
      chk1("reset out_valid", out_valid, 1'b0);
      chk1("reset out_id", out_id, 1'b0);
      chk32("reset out_result", out_result, 32'h0);
      chk1("reset out_overflow", out_overflow, 1'b0);
      chk1("reset busy", busy, 1'b0);
      chk1("reset req0_ready", req0_ready, 1'b0);
      chk1("reset req1_ready", req1_ready, 1'b0);
      @(posedge clk); #1;
      req1_valid = 1'b1; req1_a = 32'd9; req1_b = 32'd9;
      @(posedge clk); #1;
      reset = 1'b0; req1_valid = 1'b0;

      // directed arithmetic
      issue(0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
      expect_out("add ovf", 1'b0, 32'h8000_0000, 1'b1);
      issue(1, 32'd5, 32'd7, 1'b1);
      expect_out("sub neg", 1'b1, 32'hFFFF_FFFE, 1'b0);
      issue(0, 32'h0, 32'h8000_0000, 1'b1);
      expect_out("sub minint", 1'b0, 32'h8000_0000, 1'b1);
      issue(1, 32'hFFFF_FFFF, 32'h1, 1'b0);
      expect_out("add wrap", 1'b1, 32'h0, 1'b0);
      issue(0, 32'h8000_0000, 32'h1, 1'b1);
      expect_out("sub underflow", 1'b0, 32'h7FFF_FFFF, 1'b1);

      // tie-break: both held valid for four results
      reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      req0_a = 32'd10;  req0_b = 32'd3; req0_sub = 1'b0;
      req1_a = 32'd100; req1_b = 32'd1; req1_sub = 1'b1;
      req0_valid = 1'b1; req1_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
`ifdef ADDER_ARB_RR_EN
         if (k % 2 == 1) expect_out("tie", 1'b1, 32'd99, 1'b0);
         else            expect_out("tie", 1'b0, 32'd13, 1'b0);
`else
         expect_out("tie", 1'b0, 32'd13, 1'b0);
`endif
      end
      @(posedge clk); #1;
      req0_valid = 1'b0; req1_valid = 1'b0;

      // backpressure: DONE held, no grants, then grant right after handshake
      out_ready = 1'b0;
      issue(0, 32'h1234_5678, 32'h1111_1111, 1'b0);
      expect_out("bp", 1'b0, 32'h2345_6789, 1'b0);
      @(posedge clk); #1;
      req1_valid = 1'b1; req1_a = 32'd3; req1_b = 32'd4; req1_sub = 1'b0;
      repeat (5) begin
         @(negedge clk);
         chk1("bp out_valid", out_valid, 1'b1);
         chk32("bp out_result", out_result, 32'h2345_6789);
         chk1("bp out_id", out_id, 1'b0);
         chk1("bp req0_ready", req0_ready, 1'b0);
         chk1("bp req1_ready", req1_ready, 1'b0);
         chk1("bp busy", busy, 1'b1);
      end
      @(posedge clk); #1 out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk1("bp grant after handshake", req1_ready, 1'b1);
      @(posedge clk); #1 req1_valid = 1'b0;
      expect_out("bp next", 1'b1, 32'd7, 1'b0);

      // reset while in CALC drops the op and the priority pointer
      issue(0, 32'd1, 32'd2, 1'b0);
      reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      chk1("calc reset out_valid", out_valid, 1'b0);
      chk1("calc reset busy", busy, 1'b0);
      repeat (4) begin
         @(negedge clk);
         chk1("calc reset no result", out_valid, 1'b0);
      end
      @(posedge clk); #1;
      req0_a = 32'd20; req0_b = 32'd22; req0_sub = 1'b0;
      req1_a = 32'd1;  req1_b = 32'd2;  req1_sub = 1'b1;
      req0_valid = 1'b1; req1_valid = 1'b1;
      expect_out("post reset tie", 1'b0, 32'd42, 1'b0);
      @(posedge clk); #1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      repeat (3) @(posedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
